mosaic_bayer_encoder: RTL and testbench
=======================================

Name: mosaic_bayer_encoder

Overview:
Converts a raster RGB pixel stream into a single-channel 8-bit Bayer stream, i.e. the inverse of the demosaic blocks. It drives the demosaic input directly, for loopback testing and for synthetic raw-frame generation. After each frame it appends the zero-valued flush rows that the downstream line buffers need to drain. It then frames the output with valid and done strobes.

Parameters:
width, 1920, active pixels per line
height, 1080, active lines per frame
kernelSize, 7, downstream kernel size; boundaryWidth = (kernelSize-1)/2
(derived) flushPixels = width*(boundaryWidth+1); framePixels = width*height + flushPixels

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
iR  input  8  red component of input pixel
iG  input  8  green component of input pixel
iB  input  8  blue component of input pixel
iValid  input  1  input pixel present
oReady  output  1  block accepts a pixel this cycle
oData  output  8  Bayer sample
oValid  output  1  oData valid
oDone  output  1  one-cycle pulse on the last sample of a frame, including flush
xCnt  output  32  column of the current oData (0 during flush)
yCnt  output  32  row of the current oData (0 during flush)
frameCnt  output  16  completed frames, wraps at 2^16
oChecksum  output  32  per-frame byte sum (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: oData=0, oValid=0, oDone=0, xCnt=0, yCnt=0, frameCnt=0, oChecksum=0; state=ACTIVE; internal x/y/flush counters=0.
- Reset mid-frame: the partial frame is dropped, nothing is flushed, and the counters restart at pixel (0,0).
- States:
  - ACTIVE: image pixels.
  - FLUSH: zero rows.
- oReady = 1 in ACTIVE and 0 in FLUSH. This is combinational from state only, never from iValid.
- Accept = iValid & oReady.
- Latency: one cycle. The sample accepted in cycle n appears on oData/oValid in cycle n+1, with xCnt/yCnt equal to that pixel's x/y.
- Channel selection by {y[0],x[0]}:
  - 00 -> G
  - 01 -> B
  - 10 -> R
  - 11 -> G
- ACTIVE operation:
  - On accept, x increments.
  - At x=width-1, x wraps to 0 and y increments.
  - Accepting (width-1, height-1) moves the state to FLUSH and clears the flush counter.
  - Cycles without accept give oValid=0, and oData holds its last value.
- FLUSH operation:
  - Emits one sample per cycle with oData=0, oValid=1, xCnt=yCnt=0. Emission is unconditional and has no stall.
  - The flush counter increments each cycle.
  - On the cycle it emits its flushPixels-th sample, oDone=1 and frameCnt increments in the same cycle, wrapping 0xFFFF->0.
  - The state returns to ACTIVE with x=y=0, so oReady is 1 in the cycle that oDone is high.
- Simultaneous events: iValid while in FLUSH is ignored, and upstream must hold the pixel until oReady. Reset has priority over every other event.
- Frame length: exactly framePixels oValid pulses per frame, matching the demosaic totalCycles = width*(height+2+boundaryWidth-1).
- Arithmetic: counters compare against width-1, height-1 and flushPixels-1. No overflow occurs inside a frame.

Optional Feature:
MOSAIC_CHECKSUM_EN
- Defined:
  - A 32-bit accumulator adds oData (zero-extended) on every oValid, wrapping modulo 2^32.
  - On the oDone cycle, oChecksum is loaded with the accumulator plus that final sample, and the accumulator clears.
  - oChecksum then holds until the next oDone or reset.
- Undefined: oChecksum is tied to 0 and no accumulator is built.

Test Plan:
1. Pattern check. Setup: width=4, height=4, kernelSize=7. Stimulus: continuous iValid with iR=0x10+idx, iG=0x20+idx, iB=0x30+idx, where idx is the pixel index. Required response:
   - Row 0 oData = 0x20,0x31,0x22,0x33; row 1 oData = 0x14,0x25,0x16,0x27.
   - Then 16 zero samples.
   - 32 oValid pulses in total; oDone on the 32nd; frameCnt=1.
2. Backpressure. Stimulus: hold iValid=1 through the flush. Required response: oReady=0 for exactly 16 cycles starting the cycle after pixel (3,3) is accepted, and no input is consumed during them.
3. Gapped input. Stimulus: iValid toggling 1,0,1,0. Required response: oValid follows one cycle later, xCnt/yCnt advance only on accepted pixels, and the frame still totals 32 samples.
4. Mid-frame reset. Stimulus: assert reset after pixel (2,1) for one cycle. Required response: next cycle oValid=0, frameCnt=0, no flush; the next accepted pixel reports xCnt=0, yCnt=0.
5. Back-to-back frames. Stimulus: two consecutive frames. Required response: frame 2 pixel (0,0) is accepted in the oDone cycle, no bubble occurs, and frameCnt reads 2 after the second oDone.
6. Checksum (with MOSAIC_CHECKSUM_EN defined). Stimulus: all inputs 0xFF, width=4, height=4. Required response: oChecksum=16*255=0x00000FF0 at oDone, held through frame 2 until its oDone.

Source files
------------

// File: rtl/mosaic_bayer_encoder.sv
// Raster RGB to single-channel GB/RG Bayer encoder; appends zero flush rows after each frame.
// Define MOSAIC_CHECKSUM_EN to build the per-frame byte checksum on oChecksum.
module mosaic_bayer_encoder #(
    parameter int width      = 1920,
    parameter int height     = 1080,
    parameter int kernelSize = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    input  logic        iValid,
    output logic        oReady,
    output logic [7:0]  oData,
    output logic        oValid,
    output logic        oDone,
    output logic [31:0] xCnt,
    output logic [31:0] yCnt,
    output logic [15:0] frameCnt,
    output logic [31:0] oChecksum
);

    localparam int boundary_width = (kernelSize - 1) / 2;
    localparam int flush_pixels   = width * (boundary_width + 1);

    localparam logic [31:0] x_last     = 32'(width - 1);
    localparam logic [31:0] y_last     = 32'(height - 1);
    localparam logic [31:0] flush_last = 32'(flush_pixels - 1);

    typedef enum logic {
        ACTIVE = 1'b0,
        FLUSH  = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] x_reg, x_next;
    logic [31:0] y_reg, y_next;
    logic [31:0] flush_reg, flush_next;
    logic [7:0]  data_reg, data_next;
    logic        valid_reg, valid_next;
    logic        done_reg, done_next;
    logic [31:0] xcnt_reg, xcnt_next;
    logic [31:0] ycnt_reg, ycnt_next;
    logic [15:0] frame_reg, frame_next;

    logic        accept;
    logic [7:0]  bayer_sample;

    assign oReady = (state_reg == ACTIVE);
    assign accept = iValid & oReady;

    // GB on even rows, RG on odd rows
    always_comb begin
        bayer_sample = iG;
        case ({y_reg[0], x_reg[0]})
            2'b00:   bayer_sample = iG;
            2'b01:   bayer_sample = iB;
            2'b10:   bayer_sample = iR;
            default: bayer_sample = iG;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        flush_next = flush_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        done_next  = 1'b0;
        xcnt_next  = xcnt_reg;
        ycnt_next  = ycnt_reg;
        frame_next = frame_reg;

        case (state_reg)
            ACTIVE: begin
                if (accept) begin
                    valid_next = 1'b1;
                    data_next  = bayer_sample;
                    xcnt_next  = x_reg;
                    ycnt_next  = y_reg;
                    if (x_reg == x_last) begin
                        x_next = '0;
                        if (y_reg == y_last) begin
                            y_next     = '0;
                            flush_next = '0;
                            state_next = FLUSH;
                        end else begin
                            y_next = y_reg + 32'd1;
                        end
                    end else begin
                        x_next = x_reg + 32'd1;
                    end
                end
            end
            FLUSH: begin
                valid_next = 1'b1;
                data_next  = '0;
                xcnt_next  = '0;
                ycnt_next  = '0;
                // Last flush sample closes the frame; ACTIVE resumes so the next
                // frame's first pixel can be taken in the same cycle as oDone.
                if (flush_reg == flush_last) begin
                    done_next  = 1'b1;
                    frame_next = frame_reg + 16'd1;
                    flush_next = '0;
                    state_next = ACTIVE;
                end else begin
                    flush_next = flush_reg + 32'd1;
                end
            end
            default: state_next = ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACTIVE;
            x_reg     <= '0;
            y_reg     <= '0;
            flush_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            xcnt_reg  <= '0;
            ycnt_reg  <= '0;
            frame_reg <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            flush_reg <= flush_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
            xcnt_reg  <= xcnt_next;
            ycnt_reg  <= ycnt_next;
            frame_reg <= frame_next;
        end
    end

    assign oData    = data_reg;
    assign oValid   = valid_reg;
    assign oDone    = done_reg;
    assign xCnt     = xcnt_reg;
    assign yCnt     = ycnt_reg;
    assign frameCnt = frame_reg;

`ifdef MOSAIC_CHECKSUM_EN
    logic [31:0] acc_reg, acc_next;
    logic [31:0] sum_reg, sum_next;
    logic [31:0] acc_plus;

    // Summed alongside the output register so the total is visible with oDone.
    always_comb begin
        acc_plus = acc_reg + {24'd0, data_next};
        acc_next = acc_reg;
        sum_next = sum_reg;
        if (valid_next) begin
            if (done_next) begin
                sum_next = acc_plus;
                acc_next = '0;
            end else begin
                acc_next = acc_plus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
            sum_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            sum_reg <= sum_next;
        end
    end

    assign oChecksum = sum_reg;
`else
    assign oChecksum = '0;
`endif

endmodule

// File: tb/tb_mosaic_bayer_encoder.sv
// Scoreboard bench for mosaic_bayer_encoder on a 4x4 frame with kernelSize 7.
module tb_mosaic_bayer_encoder;

    localparam int W       = 4;
    localparam int H       = 4;
    localparam int K       = 7;
    localparam int FLUSH_N = W * ((K - 1) / 2 + 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  iR = '0;
    logic [7:0]  iG = '0;
    logic [7:0]  iB = '0;
    logic        iValid = 1'b0;
    logic        oReady;
    logic [7:0]  oData;
    logic        oValid;
    logic        oDone;
    logic [31:0] xCnt;
    logic [31:0] yCnt;
    logic [15:0] frameCnt;
    logic [31:0] oChecksum;

    mosaic_bayer_encoder #(
        .width      (W),
        .height     (H),
        .kernelSize (K)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iR        (iR),
        .iG        (iG),
        .iB        (iB),
        .iValid    (iValid),
        .oReady    (oReady),
        .oData     (oData),
        .oValid    (oValid),
        .oDone     (oDone),
        .xCnt      (xCnt),
        .yCnt      (yCnt),
        .frameCnt  (frameCnt),
        .oChecksum (oChecksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [7:0]  data;
        int          x;
        int          y;
        bit          done;
        logic [15:0] frame;
        logic [31:0] ck;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: next pixel position, remaining stall cycles, frame totals.
    int          px = 0;
    int          py = 0;
    int          flush_left = 0;
    int          mode = 0;
    logic [15:0] frames = '0;
    logic [31:0] cur_ck = '0;
    logic [31:0] frame_sum = '0;
    logic [7:0]  cur_r = '0;
    logic [7:0]  cur_g = '0;
    logic [7:0]  cur_b = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [7:0] bayer_pick(input int x, input int y,
                                              input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
        if (y % 2 == 0) return (x % 2 == 0) ? g : b;
        else            return (x % 2 == 0) ? r : g;
    endfunction

    task automatic new_pixel();
        int idx;
        idx = py * W + px;
        case (mode)
            0: begin
                cur_r = 8'(16 + idx);
                cur_g = 8'(32 + idx);
                cur_b = 8'(48 + idx);
            end
            1: begin
                cur_r = 8'($urandom);
                cur_g = 8'($urandom);
                cur_b = 8'($urandom);
            end
            default: begin
                cur_r = 8'hFF;
                cur_g = 8'hFF;
                cur_b = 8'hFF;
            end
        endcase
    endtask

    task automatic push_item(input int due, input logic [7:0] d, input int x, input int y,
                             input bit done);
        exp_t e;
        frame_sum = frame_sum + {24'd0, d};
        if (done) begin
            frames    = frames + 16'd1;
            cur_ck    = frame_sum;
            frame_sum = '0;
        end
        e.due   = due;
        e.data  = d;
        e.x     = x;
        e.y     = y;
        e.done  = done;
        e.frame = frames;
`ifdef MOSAIC_CHECKSUM_EN
        e.ck    = cur_ck;
`else
        e.ck    = '0;
`endif
        q.push_back(e);
    endtask

    task automatic accept_model();
        push_item(cyc + 1, bayer_pick(px, py, cur_r, cur_g, cur_b), px, py, 1'b0);
        if (px == W - 1) begin
            px = 0;
            if (py == H - 1) begin
                py = 0;
                for (int i = 0; i < FLUSH_N; i++)
                    push_item(cyc + 2 + i, 8'h00, 0, 0, i == FLUSH_N - 1);
                flush_left = FLUSH_N;
            end else begin
                py++;
            end
        end else begin
            px++;
        end
        new_pixel();
    endtask

    task automatic cycle_step(input bit v);
        @(negedge clk);
        iValid = v;
        iR = cur_r;
        iG = cur_g;
        iB = cur_b;
        chk("oReady", 64'(oReady), 64'(flush_left == 0));
        if (flush_left == 0) begin
            if (v) accept_model();
        end else begin
            flush_left--;
        end
    endtask

    // vmode: 0 continuous (held through flush), 1 alternating 1/0, 2 random gaps
    task automatic run_frame(input int vmode);
        logic [15:0] f0;
        int budget;
        bit v;
        f0 = frames;
        budget = 0;
        while (!(frames != f0 && flush_left == 0) && budget < 400) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 0);
                default: v = ($urandom_range(0, 9) < 7);
            endcase
            cycle_step(v);
            budget++;
        end
        if (budget >= 400) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d cycles, expected frame completion", budget);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_sample: got no oValid, expected data %0h due cycle %0d",
                         q[0].data, q[0].due);
                void'(q.pop_front());
            end
            if (oValid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got data %0h, expected no oValid (cycle %0d)",
                             oData, cyc);
                end else begin
                    e = q.pop_front();
                    chk("sample_cycle", 64'(cyc), 64'(e.due));
                    chk("oData", 64'(oData), 64'(e.data));
                    chk("xCnt", 64'(xCnt), 64'(e.x));
                    chk("yCnt", 64'(yCnt), 64'(e.y));
                    chk("oDone", 64'(oDone), 64'(e.done));
                    chk("frameCnt", 64'(frameCnt), 64'(e.frame));
                    chk("oChecksum", 64'(oChecksum), 64'(e.ck));
                    $display("sample cyc=%0d data=%02h x=%0d y=%0d done=%0b frame=%0d ck=%08h",
                             cyc, oData, xCnt, yCnt, oDone, frameCnt, oChecksum);
                end
            end else begin
                chk("oDone_idle", 64'(oDone), 64'd0);
            end
        end
    end

    initial begin : driver
        int guard;
        mode = 0;
        new_pixel();
        repeat (3) @(negedge clk);
        chk("reset_oValid", 64'(oValid), 64'd0);
        chk("reset_oData", 64'(oData), 64'd0);
        chk("reset_oDone", 64'(oDone), 64'd0);
        chk("reset_xCnt", 64'(xCnt), 64'd0);
        chk("reset_yCnt", 64'(yCnt), 64'd0);
        chk("reset_frameCnt", 64'(frameCnt), 64'd0);
        chk("reset_oChecksum", 64'(oChecksum), 64'd0);
        chk("reset_oReady", 64'(oReady), 64'd1);
        reset = 1'b0;

        // Pattern frame with valid held through the flush, then an all-0xFF frame back to back
        run_frame(0);
        mode = 2;
        new_pixel();
        run_frame(0);

        mode = 1;
        new_pixel();
        run_frame(1);
        run_frame(2);

        // Reset right after pixel (2,1) has been accepted
        guard = 0;
        while (!(px == 3 && py == 1) && guard < 100) begin
            cycle_step(1'b1);
            guard++;
        end
        @(negedge clk);
        reset = 1'b1;
        iValid = 1'b1;
        px = 0;
        py = 0;
        flush_left = 0;
        frames = '0;
        cur_ck = '0;
        frame_sum = '0;
        new_pixel();
        @(negedge clk);
        reset = 1'b0;
        iValid = 1'b0;
        chk("post_reset_oValid", 64'(oValid), 64'd0);
        chk("post_reset_frameCnt", 64'(frameCnt), 64'd0);
        chk("post_reset_oReady", 64'(oReady), 64'd1);

        run_frame(2);
        run_frame(0);
        repeat (20) cycle_step(1'b0);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
